// File: rtl/gaussian_window_ctrl_pkg.sv
// Shared definitions for the 5x5 Gaussian window sequencer: kernel radius,
// controller state encoding and the counter-width helper.
package gaussian_window_ctrl_pkg;

  localparam int KERNEL_RADIUS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of a counter that must hold values up to value-1.
  function automatic int clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/gaussian_window_ctrl_raster_counter.sv
// Raster position counter: x runs 0..W_MAX-1 fastest, then y 0..H_MAX-1.
// Both wrap to zero after the final position so the next frame starts clean.
module raster_counter #(
  parameter int W_MAX = 722,
  parameter int H_MAX = 542,
  parameter int XW    = 10,
  parameter int YW    = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_LAST = XW'(W_MAX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H_MAX - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_end;
  logic          w_last;

  assign w_x_end = (r_x == X_LAST);
  assign w_last  = w_x_end && (r_y == Y_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (en) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign x    = r_x;
  assign y    = r_y;
  assign last = w_last;

endmodule

// File: rtl/gaussian_window_ctrl.sv
// Frame sequencer for the 5x5 Gaussian stage: walks the padded raster, pops
// input pixels, injects flush zeros and pushes op_gaussian results downstream.
module gaussian_window_ctrl
  import gaussian_window_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int PAD        = KERNEL_RADIUS,
  localparam int XW        = clog2(IMG_WIDTH + 5),
  localparam int YW        = clog2(IMG_HEIGHT + 5)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          in_empty,
  output logic          in_rd_en,
  input  logic          out_afull,
  output logic          out_wr_en,
  output logic          win_shift,
  output logic          win_zero,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          busy,
  output logic          done
);

  state_t        r_state;
  state_t        w_next;
  logic          r_wr_en;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_last;
  logic          w_image;
  logic          w_out_pos;
  logic          w_step;
  logic          w_clr;

  raster_counter #(
    .W_MAX (IMG_WIDTH + PAD),
    .H_MAX (IMG_HEIGHT + PAD),
    .XW    (XW),
    .YW    (YW)
  ) u_raster (
    .clock (clock),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_step),
    .x     (w_x),
    .y     (w_y),
    .last  (w_last)
  );

  assign w_image   = (w_x < XW'(IMG_WIDTH)) && (w_y < YW'(IMG_HEIGHT));
  assign w_out_pos = (w_x >= XW'(PAD)) && (w_y >= YW'(PAD));
  // Flush steps never touch the input FIFO, so they proceed while it is empty.
  assign w_step    = (r_state == ST_SCAN) && !out_afull && (!w_image || !in_empty);
  assign w_clr     = (r_state == ST_IDLE) && start;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_wr_en <= 1'b0;
    end else begin
      r_state <= w_next;
      // op_gaussian registers its result, so the push trails the step by one cycle.
      r_wr_en <= w_step && w_out_pos;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_next    = r_state;
    win_shift = 1'b0;
    in_rd_en  = 1'b0;
    win_zero  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_SCAN;
      end
      ST_SCAN: begin
        busy      = 1'b1;
        win_shift = w_step;
        in_rd_en  = w_step && w_image;
        win_zero  = w_step && !w_image;
        if (w_step && w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy   = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign out_wr_en = r_wr_en;
  assign x         = w_x;
  assign y         = w_y;

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Directed-plus-random bench for gaussian_window_ctrl on an 8x4 frame, checked
// against a position-index model of the padded raster scan.
module tb_gaussian_window_ctrl;

  localparam int W         = 8;
  localparam int H         = 4;
  localparam int PAD       = 2;
  localparam int XW        = $clog2(W + 5);
  localparam int YW        = $clog2(H + 5);
  localparam int COLS      = W + PAD;
  localparam int ROWS      = H + PAD;
  localparam int STEPS     = COLS * ROWS;
  localparam int OUT_DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_empty = 1'b1;
  logic          out_afull = 1'b0;
  logic          in_rd_en, out_wr_en, win_shift, win_zero, busy, done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  always #5 clock = ~clock;

  gaussian_window_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_afull (out_afull),
    .out_wr_en (out_wr_en),
    .win_shift (win_shift),
    .win_zero  (win_zero),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Environment: input FIFO fill, output FIFO fill, stall controls.
  int in_cnt      = 0;
  int out_cnt     = 0;
  bit force_afull = 0;
  int empty_mode  = 0;
  bit drain_rand  = 0;
  int cyc         = 0;

  // Reference model: frame phase plus linear step index into the padded raster.
  typedef enum {M_IDLE, M_SCAN, M_DRAIN, M_DONE} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_idx   = 0;
  bit      m_wr_due = 0;
  int      centers[$];

  int n_step, n_pop, n_zero, n_wr, n_done, start_cyc, done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    n_step = 0; n_pop = 0; n_zero = 0; n_wr = 0; n_done = 0;
    start_cyc = 0; done_cyc = 0;
    centers.delete();
  endtask

  // One clock cycle: drive inputs, check mid-cycle, advance model at the edge.
  task automatic tick(input bit rst, input bit st);
    bit stall, flush, step;
    int px, py, c;
    reset = rst;
    start = st;
    case (empty_mode)
      0:       stall = 1'b0;
      1:       stall = cyc[0];
      default: stall = ($urandom_range(0, 2) == 0);
    endcase
    in_empty  = (in_cnt == 0) || stall;
    out_afull = force_afull || ((OUT_DEPTH - out_cnt) <= 1);
    #4;
    px    = m_idx % COLS;
    py    = m_idx / COLS;
    flush = (px >= W) || (py >= H);
    step  = (m_phase == M_SCAN) && !out_afull && (flush || !in_empty);
    check("win_shift", win_shift, step);
    check("in_rd_en",  in_rd_en,  step && !flush);
    check("win_zero",  win_zero,  step && flush);
    check("out_wr_en", out_wr_en, m_wr_due);
    check("busy",      busy,      (m_phase == M_SCAN) || (m_phase == M_DRAIN));
    check("done",      done,      m_phase == M_DONE);
    check("x", x, (m_phase == M_SCAN) ? px : 0);
    check("y", y, (m_phase == M_SCAN) ? py : 0);
    if (out_wr_en) begin
      check("out_fifo_room", out_cnt < OUT_DEPTH, 1);
      c = (centers.size() > 0) ? centers.pop_front() : -1;
      check("write_center_order", c, n_wr);
      n_wr++;
      out_cnt++;
    end
    if (win_shift) n_step++;
    if (win_zero)  n_zero++;
    if (in_rd_en) begin
      n_pop++;
      if (in_cnt > 0) in_cnt--;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (out_cnt > 0 && (!drain_rand || $urandom_range(0, 1) == 1)) out_cnt--;
    if (rst) begin
      m_phase  = M_IDLE;
      m_idx    = 0;
      m_wr_due = 0;
      centers.delete();
    end else begin
      case (m_phase)
        M_IDLE: begin
          m_wr_due = 0;
          if (st) begin
            m_phase   = M_SCAN;
            m_idx     = 0;
            start_cyc = cyc;
          end
        end
        M_SCAN: begin
          m_wr_due = step && (px >= PAD) && (py >= PAD);
          if (m_wr_due) centers.push_back((py - PAD) * W + (px - PAD));
          if (step) m_idx++;
          if (m_idx == STEPS) m_phase = M_DRAIN;
        end
        M_DRAIN: begin
          m_wr_due = 0;
          m_phase  = M_DONE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Run from the current point until the model returns to IDLE.
  task automatic finish_frame(input bit noise);
    int budget;
    budget = 0;
    while (m_phase != M_IDLE && budget < 2000) begin
      tick(1'b0, noise && ($urandom_range(0, 3) == 0));
      budget++;
    end
    check("frame_timeout", m_phase == M_IDLE, 1);
  endtask

  task automatic run_to_step(input int target);
    int budget;
    budget = 0;
    while (m_phase == M_SCAN && m_idx < target && budget < 2000) begin
      tick(1'b0, 1'b0);
      budget++;
    end
    check("reach_step_timeout", m_idx, target);
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_steps"},  n_step, STEPS);
    check({tag, "_pops"},   n_pop,  W * H);
    check({tag, "_zeros"},  n_zero, STEPS - W * H);
    check({tag, "_writes"}, n_wr,   W * H);
    check({tag, "_dones"},  n_done, 1);
  endtask

  initial begin
    logic [XW-1:0] x_hold;
    logic [YW-1:0] y_hold;

    // Reset state, including start coinciding with reset.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    check("reset_busy", busy, 0);
    check("reset_x", x, 0);

    // 1: preloaded FIFO, no backpressure, back-to-back steps.
    in_cnt = W * H; empty_mode = 0; drain_rand = 0;
    clear_counts();
    tick(1'b0, 1'b1);
    finish_frame(1'b0);
    check_totals("t1");
    check("t1_start_to_done", done_cyc - start_cyc, STEPS + 2);
    tick(1'b0, 1'b0);

    // 2: input FIFO empty every other cycle, then randomly, with random drain.
    in_cnt = W * H; empty_mode = 1; drain_rand = 1;
    clear_counts();
    tick(1'b0, 1'b1);
    finish_frame(1'b0);
    check_totals("t2a");
    in_cnt = W * H; empty_mode = 2;
    clear_counts();
    tick(1'b0, 1'b1);
    finish_frame(1'b0);
    check_totals("t2b");

    // 3: out_afull forced for 10 cycles mid-row.
    in_cnt = W * H; empty_mode = 0; drain_rand = 0;
    clear_counts();
    tick(1'b0, 1'b1);
    run_to_step(COLS * 3 + 4);
    x_hold = x;
    y_hold = y;
    force_afull = 1;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    check("t3_x_frozen", x, x_hold);
    check("t3_y_frozen", y, y_hold);
    force_afull = 0;
    finish_frame(1'b0);
    check_totals("t3");

    // 4: reset at step 20, then a fresh frame.
    in_cnt = W * H;
    clear_counts();
    tick(1'b0, 1'b1);
    run_to_step(20);
    tick(1'b1, 1'b0);
    check("t4_busy_after_reset", busy, 0);
    check("t4_x_after_reset", x, 0);
    check("t4_y_after_reset", y, 0);
    tick(1'b0, 1'b0);
    check("t4_no_done", n_done, 0);
    in_cnt = W * H;
    clear_counts();
    tick(1'b0, 1'b1);
    finish_frame(1'b0);
    check_totals("t4");

    // 5: stray start pulses during SCAN/DRAIN/DONE, random stalls.
    in_cnt = W * H; empty_mode = 2; drain_rand = 1;
    clear_counts();
    tick(1'b0, 1'b1);
    run_to_step(30);
    tick(1'b0, 1'b1);
    while (m_phase != M_DONE && n_step < STEPS + 5 && cyc < 50000) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("t5_idle_after_done_start", busy, 0);
    tick(1'b0, 1'b0);
    check("t5_still_idle", busy, 0);
    check_totals("t5");
    in_cnt = W * H;
    clear_counts();
    tick(1'b0, 1'b1);
    finish_frame(1'b1);
    check_totals("t5b");

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
